// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED pattern sequencer: the 2-bit mode
// encodings presented on the mode input and the sequencer state encoding.
// ---------------------------------------------------------------------------
package led_seq_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ON_PH  = 2'd1,
        OFF_PH = 2'd2
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
// Ports:
//   CLOCK_50  in   system clock
//   reset     in   synchronous active-high reset
//   clear     in   synchronous clear back to 0, wins over enable
//   enable    in   count when high, hold when low
//   tick      out  high while the counter sits at DIV-1 and enable is high
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV = 5000000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            W    = $clog2(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    assign tick = enable && (cnt_q == LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer
// Drives the status LED as off, steady on, continuous blink, or a burst of
// N pulses. Pulse timing is ON_TICKS high / OFF_TICKS low, one tick being
// TICK_DIV clock cycles.
// Ports:
//   CLOCK_50  in   50 MHz system clock
//   reset     in   synchronous active-high reset
//   mode      in   00 OFF, 01 ON, 10 BLINK, 11 BURST
//   count     in   burst pulse count, captured when a burst start is accepted
//   start     in   single-cycle burst request (only used with mode=BURST)
//   LED       out  registered LED drive
//   busy      out  high while a pulse sequence is running
//   done      out  one-cycle pulse when a burst finishes
// ---------------------------------------------------------------------------
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV  = 5000000,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic [3:0] count,
    input  logic       start,
    output logic       LED,
    output logic       busy,
    output logic       done
);

    localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);

    state_e          state_q, state_d;
    logic            run_burst_q, run_burst_d;
    logic [3:0]      remaining_q, remaining_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            led_q, led_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            psc_clear;
    logic            tick;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clear    (psc_clear),
        .enable   (state_q != IDLE),
        .tick     (tick)
    );

    always_comb begin
        state_d     = state_q;
        run_burst_d = run_burst_q;
        remaining_d = remaining_q;
        phase_d     = phase_q;
        done_d      = 1'b0;
        psc_clear   = 1'b0;

        case (state_q)
            IDLE: begin
                if (mode == MODE_BLINK) begin
                    state_d     = ON_PH;
                    run_burst_d = 1'b0;
                    phase_d     = '0;
                    psc_clear   = 1'b1;
                end else if (mode == MODE_BURST && start) begin
                    remaining_d = count;
                    if (count == 4'd0) begin
                        // Empty burst: report completion without pulsing.
                        done_d = 1'b1;
                    end else begin
                        state_d     = ON_PH;
                        run_burst_d = 1'b1;
                        phase_d     = '0;
                        psc_clear   = 1'b1;
                    end
                end
            end

            ON_PH: begin
                if (!run_burst_q && mode != MODE_BLINK) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (phase_q == ON_LAST) begin
                        state_d = OFF_PH;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end

            OFF_PH: begin
                if (!run_burst_q && mode != MODE_BLINK) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (phase_q == OFF_LAST) begin
                        phase_d = '0;
                        if (run_burst_q) begin
                            // Saturating compare keeps remaining from wrapping.
                            if (remaining_q <= 4'd1) begin
                                remaining_d = 4'd0;
                                state_d     = IDLE;
                                done_d      = 1'b1;
                            end else begin
                                remaining_d = remaining_q - 4'd1;
                                state_d     = ON_PH;
                            end
                        end else begin
                            state_d = ON_PH;
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register on the
        // same edge the state changes.
        led_d  = (state_d == ON_PH) || (state_d == IDLE && mode == MODE_ON);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            run_burst_q <= 1'b0;
            remaining_q <= 4'd0;
            phase_q     <= '0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_burst_q <= run_burst_d;
            remaining_q <= remaining_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign LED  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_sequencer
// Directed stimulus for the LED sequencer with TICK_DIV=4, ON_TICKS=2,
// OFF_TICKS=3 (8 cycles on, 12 off). Stimulus pushes the expected output
// transitions {LED,busy,done} with their cycle numbers into a queue; a
// monitor pops one entry for every change it sees on the outputs.
// ---------------------------------------------------------------------------
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic [3:0] count;
    logic       start;
    logic       LED;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         at;
        logic [2:0] v;
    } ev_t;

    ev_t        exp_q[$];
    logic       mon_en = 1'b0;
    logic [2:0] prev_v = 3'b000;

    led_pattern_sequencer #(
        .TICK_DIV  (4),
        .ON_TICKS  (2),
        .OFF_TICKS (3)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .mode     (mode),
        .count    (count),
        .start    (start),
        .LED      (LED),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int at, input logic [2:0] v);
        ev_t e;
        e.at = at;
        e.v  = v;
        exp_q.push_back(e);
    endtask

    // Burst of n pulses whose first ON phase starts after edge e.
    task automatic push_burst(input int e, input int n);
        push(e, 3'b110);
        for (int p = 0; p < n; p++) begin
            push(e + 20 * p + 8, 3'b010);
            if (p < n - 1) push(e + 20 * p + 20, 3'b110);
        end
        push(e + 20 * n, 3'b001);
        push(e + 20 * n + 1, 3'b000);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every output change must match the next queued expectation.
    always @(negedge clk) begin
        logic [2:0] cur;
        ev_t        e;
        if (mon_en) begin
            cur = {LED, busy, done};
            if (cur !== prev_v) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%b expected no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at != cyc || e.v !== cur) begin
                        errors++;
                        $display("FAIL transition cyc=%0d got=%b required cyc=%0d val=%b",
                                 cyc, cur, e.at, e.v);
                    end else begin
                        $display("ok   transition cyc=%0d {LED,busy,done}=%b", cyc, cur);
                    end
                end
                prev_v = cur;
            end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL missed_transition cyc=%0d got=%b required cyc=%0d val=%b",
                         cyc, cur, e.at, e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got timeout required finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        reset = 1'b1;
        mode  = 2'b00;
        count = 4'd0;
        start = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checks++;
        if ({LED, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state got=%b required 000", {LED, busy, done});
        end else begin
            $display("ok   reset_state {LED,busy,done}=000");
        end
        reset  = 1'b0;
        prev_v = 3'b000;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Level modes in IDLE
        mode = 2'b01;
        push(cyc + 1, 3'b100);
        repeat (3) @(negedge clk);
        mode = 2'b00;
        push(cyc + 1, 3'b000);
        repeat (3) @(negedge clk);

        // Continuous blink, aborted 5 cycles into the fourth ON phase
        mode = 2'b10;
        e = cyc + 1;
        for (int p = 0; p < 3; p++) begin
            push(e + 20 * p, 3'b110);
            push(e + 20 * p + 8, 3'b010);
        end
        push(e + 60, 3'b110);
        wait_until(e + 64);
        mode = 2'b00;
        push(e + 65, 3'b000);
        repeat (4) @(negedge clk);

        // Burst of 3
        mode  = 2'b11;
        count = 4'd3;
        start = 1'b1;
        e = cyc + 1;
        push_burst(e, 3);
        @(negedge clk);
        start = 1'b0;
        wait_until(e + 65);

        // Empty burst
        count = 4'd0;
        start = 1'b1;
        e = cyc + 1;
        push(e, 3'b001);
        push(e + 1, 3'b000);
        @(negedge clk);
        start = 1'b0;
        wait_until(e + 5);

        // Burst of 2 with disturbances that must be ignored
        count = 4'd2;
        start = 1'b1;
        e = cyc + 1;
        push_burst(e, 2);
        @(negedge clk);
        start = 1'b0;
        wait_until(e + 3);
        start = 1'b1;
        count = 4'd9;
        @(negedge clk);
        start = 1'b0;
        wait_until(e + 10);
        mode = 2'b00;
        wait_until(e + 22);
        mode  = 2'b10;
        start = 1'b1;
        @(negedge clk);
        mode  = 2'b00;
        start = 1'b0;
        wait_until(e + 45);

        // Burst of 2 abandoned by reset in the first ON phase
        mode  = 2'b11;
        count = 4'd2;
        start = 1'b1;
        e = cyc + 1;
        push(e, 3'b110);
        @(negedge clk);
        start = 1'b0;
        wait_until(e + 4);
        reset = 1'b1;
        push(e + 5, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        wait_until(e + 55);

        // Burst of 15
        count = 4'd15;
        start = 1'b1;
        e = cyc + 1;
        push_burst(e, 15);
        @(negedge clk);
        start = 1'b0;
        wait_until(e + 306);
        checks++;
        if (dut.remaining_q !== 4'd0) begin
            errors++;
            $display("FAIL remaining_end got=%0d required 0", dut.remaining_q);
        end else begin
            $display("ok   remaining_end remaining=0");
        end

        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            ev_t left;
            left = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL pending_transition got=none required cyc=%0d val=%b", left.at, left.v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Controller that sequences the board status LED through selectable patterns (off, steady on, continuous blink, counted burst) from a 50 MHz clock. It wraps the free-running divide-and-toggle LED counter in a small state machine so other logic can request "blink N times" or "blink until told to stop" without owning the timing. It sits between status-producing logic and the LED pin.

## Interface
- TICK_DIV, 5000000: clock cycles per tick (100 ms at 50 MHz); must be ≥ 2.
- ON_TICKS, 2: ticks LED is high per pulse; ≥ 1.
- OFF_TICKS, 3: ticks LED is low per pulse; ≥ 1.
- CLOCK_50  in  1  system clock, 50 MHz; only clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 BURST.
- count  in  4  burst pulse count, sampled on accepted start.
- start  in  1  single-cycle request; meaningful only with mode=BURST.
- LED  out  1  registered LED drive.
- busy  out  1  high while in ON_PH or OFF_PH.
- done  out  1  one-cycle pulse at burst completion.

## Operation
- States: IDLE, ON_PH, OFF_PH. Latched registers: run_mode (BLINK/BURST), remaining (4 bits), phase counter, prescaler.
- IDLE: LED = (mode==ON); busy=0. mode=OFF/ON are level-driven with no state change.
- IDLE, mode=BLINK: go ON_PH, run_mode=BLINK, prescaler and phase counter cleared.
- IDLE, mode=BURST, start=1: latch count into remaining; count=0 → stay IDLE, done=1 next cycle, no pulse; else go ON_PH, run_mode=BURST, counters cleared.
- ON_PH: LED=1; after ON_TICKS ticks → OFF_PH, phase counter cleared.
- OFF_PH: LED=0; after OFF_TICKS ticks: BLINK → ON_PH; BURST → remaining-1, if it reaches 0 → IDLE with done=1, else ON_PH.
- BLINK abort: in ON_PH/OFF_PH with run_mode=BLINK and mode≠BLINK → IDLE next edge; LED then follows mode per IDLE rule.
- BURST is non-preemptible: mode changes and start while busy are ignored; start is not queued.
- Tick: prescaler counts 0..TICK_DIV-1, tick asserted when at TICK_DIV-1, then wraps to 0. Prescaler runs only while busy; cleared on every IDLE→ON_PH.
- Reset (any state, any cycle): state IDLE, LED=0, busy=0, done=0, all counters 0; in-flight burst abandoned, no done.

## Timing
- All outputs registered; no combinational input→output path.
- start (or mode=BLINK) sampled at edge n in IDLE → LED=1, busy=1 after edge n+1.
- ON phase exactly ON_TICKS·TICK_DIV cycles; OFF phase exactly OFF_TICKS·TICK_DIV cycles; no jitter across pulses.
- BURST of N: busy high N·(ON_TICKS+OFF_TICKS)·TICK_DIV cycles; done high the first cycle busy is low; done never overlaps busy.
- count=0: done high the cycle after start; busy never rises.
- mode=ON/OFF in IDLE: LED reflects mode one cycle after change.
- Widths: prescaler $clog2(TICK_DIV); phase counter $clog2(max(ON_TICKS,OFF_TICKS)+1); remaining 4 bits, never decremented below 0.

## Structure
- Package led_seq_pkg: mode encodings (MODE_OFF, MODE_ON, MODE_BLINK, MODE_BURST) and state enum (IDLE, ON_PH, OFF_PH).
- One sub-module: tick_prescaler (params DIV; ports CLOCK_50, reset, clear, enable, tick), synchronous clear with priority over enable.
- FSM, phase counter and remaining counter live in led_pattern_sequencer.

## Test plan
Bench uses TICK_DIV=4, ON_TICKS=2, OFF_TICKS=3 (on 8 cycles, off 12).
- Reset held 3 cycles then released with mode=OFF → LED=0, busy=0, done=0; mode=ON → LED=1 next cycle; back to OFF → LED=0 next cycle.
- mode=BLINK for 60 cycles → LED 8 high / 12 low repeating, busy=1; mode=OFF at cycle 5 of an ON phase → LED=0, busy=0 next edge.
- mode=BURST, count=3, start pulse at edge n → 3 pulses 8 high/12 low; busy high cycles n+1..n+60; done=1 for exactly cycle n+61; LED=0 after.
- mode=BURST, count=0, start → done=1 for one cycle, LED and busy stay 0.
- During count=2 burst: repeated start, count=9, mode=OFF → ignored, exactly 2 pulses, done once; second run with reset asserted mid-ON → LED=0, busy=0 next edge, no done.
- count=15 burst → exactly 15 pulses, done after 300 cycles, remaining ends at 0 (no wrap).
